// File: rtl/adc_sar_pkg.sv
// adc_sar_pkg
//   Shared definitions for the SAR conversion sequencer:
//   - default code width and timing defaults
//   - FSM state encoding
//   - helper that sizes the shared sample/settle down-counter
package adc_sar_pkg;

  localparam int RESOLUTION_DEFAULT    = 12;
  localparam int SAMPLE_CYCLES_DEFAULT = 4;
  localparam int SETTLE_CYCLES_DEFAULT = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    SETTLE = 3'd2,
    STROBE = 3'd3,
    DONE   = 3'd4
  } sar_state_t;

  // One down-counter serves both the sample window and the per-bit settle
  // window, so it must hold the larger of the two counts.
  function automatic int cnt_width(input int sample_cycles, input int settle_cycles);
    int max_cycles;
    max_cycles = (sample_cycles > settle_cycles) ? sample_cycles : settle_cycles;
    return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/adc_sar_controller.sv
// adc_sar_controller
//   SAR conversion sequencer. On start it samples the input for SAMPLE_CYCLES
//   cycles, then resolves one code bit per step, MSB first: apply the trial
//   code, wait SETTLE_CYCLES for the DAC, strobe the comparator, keep or
//   clear the trial bit. The final code is offered on a valid/ready port.
//
// Ports
//   clk            : single clock, rising edge
//   rst            : synchronous active-high reset (aborts any conversion)
//   start_i        : conversion request, level sampled each edge
//   comp_i         : comparator result, 1 = Vin >= Vdac (keep trial bit)
//   sample_o       : sampling switch enable
//   comp_strobe_o  : comparator latch strobe, one cycle per bit
//   data_o         : trial code to the cap-array decoder
//   busy_o         : high while sampling / settling / strobing
//   result_o       : final code, stable while result_valid_o
//   result_valid_o : result available
//   result_ready_i : consumer accepts result
module adc_sar_controller
  import adc_sar_pkg::*;
#(
  parameter int RESOLUTION    = RESOLUTION_DEFAULT,
  parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  comp_i,
  output logic                  sample_o,
  output logic                  comp_strobe_o,
  output logic [RESOLUTION-1:0] data_o,
  output logic                  busy_o,
  output logic [RESOLUTION-1:0] result_o,
  output logic                  result_valid_o,
  input  logic                  result_ready_i
);

  localparam int CW = cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
  localparam int KW = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;

  localparam logic [CW-1:0]         SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0]         SETTLE_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [KW-1:0]         K_MSB       = KW'(RESOLUTION - 1);
  localparam logic [RESOLUTION-1:0] MSB_TRIAL   = {1'b1, {(RESOLUTION-1){1'b0}}};

  sar_state_t              state_reg, state_next;
  logic [CW-1:0]           cnt_reg;
  logic [KW-1:0]           k_reg;
  logic [RESOLUTION-1:0]   data_reg;
  logic [RESOLUTION-1:0]   result_reg;
  logic                    valid_reg;

  logic [RESOLUTION-1:0]   k_onehot;
  logic [RESOLUTION-1:0]   code_resolved;
  logic [RESOLUTION-1:0]   trial_next;

  // One-hot mask of the bit currently under test.
  generate
    for (genvar gi = 0; gi < RESOLUTION; gi++) begin : g_onehot
      assign k_onehot[gi] = (k_reg == KW'(gi));
    end
  endgenerate

  // Current trial code with the bit under test replaced by the comparator
  // decision; the next trial bit is the one just below it.
  assign code_resolved = (data_reg & ~k_onehot) | (k_onehot & {RESOLUTION{comp_i}});
  assign trial_next    = k_onehot >> 1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (cnt_reg == '0) state_next = (SETTLE_CYCLES == 0) ? STROBE : SETTLE;
      end
      SETTLE: begin
        if (cnt_reg == '0) state_next = STROBE;
      end
      STROBE: begin
        if (k_reg == '0) state_next = DONE;
        else             state_next = (SETTLE_CYCLES == 0) ? STROBE : SETTLE;
      end
      DONE: begin
        if (result_ready_i) state_next = start_i ? SAMPLE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: shared counter, bit index, trial code and result registers.
  // data_reg only moves on the edges that enter a new bit, so data_o is
  // constant for the whole settle + strobe window of each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      k_reg      <= K_MSB;
      data_reg   <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            cnt_reg  <= SAMPLE_LOAD;
            k_reg    <= K_MSB;
            data_reg <= '0;
          end
        end
        SAMPLE: begin
          if (cnt_reg == '0) begin
            data_reg <= MSB_TRIAL;
            cnt_reg  <= SETTLE_LOAD;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        SETTLE: begin
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CW'(1);
        end
        STROBE: begin
          if (k_reg == '0) begin
            data_reg   <= code_resolved;
            result_reg <= code_resolved;
            valid_reg  <= 1'b1;
          end else begin
            data_reg <= code_resolved | trial_next;
            k_reg    <= k_reg - KW'(1);
            cnt_reg  <= SETTLE_LOAD;
          end
        end
        DONE: begin
          if (result_ready_i) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            if (start_i) begin
              cnt_reg <= SAMPLE_LOAD;
              k_reg   <= K_MSB;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic: strobes decode straight from the state register, so
  // sample_o and comp_strobe_o are mutually exclusive by construction.
  always_comb begin
    sample_o       = (state_reg == SAMPLE);
    comp_strobe_o  = (state_reg == STROBE);
    busy_o         = (state_reg == SAMPLE) || (state_reg == SETTLE) || (state_reg == STROBE);
    data_o         = data_reg;
    result_o       = result_reg;
    result_valid_o = valid_reg;
  end

endmodule

// File: tb/tb_adc_sar_controller.sv
module tb_adc_sar_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_i, comp_i, ready;
  logic        sample, strobe, busy, valid;
  logic [11:0] data, result;
  logic [11:0] vin;
  int          comp_mode;  // 0: comparator model, 1: tied high, 2: tied low

  logic        start2, comp2, ready2;
  logic        sample2, strobe2, busy2, valid2;
  logic [11:0] data2, result2;
  logic [11:0] vin2;

  int total = 0;
  int bad   = 0;
  logic [11:0] trials[$];

  always_comb begin
    case (comp_mode)
      1:       comp_i = 1'b1;
      2:       comp_i = 1'b0;
      default: comp_i = (data <= vin);
    endcase
  end
  assign comp2 = (data2 <= vin2);

  adc_sar_controller dut (
    .clk(clk), .rst(rst), .start_i(start_i), .comp_i(comp_i),
    .sample_o(sample), .comp_strobe_o(strobe), .data_o(data), .busy_o(busy),
    .result_o(result), .result_valid_o(valid), .result_ready_i(ready)
  );

  adc_sar_controller #(.RESOLUTION(12), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .comp_i(comp2),
    .sample_o(sample2), .comp_strobe_o(strobe2), .data_o(data2), .busy_o(busy2),
    .result_o(result2), .result_valid_o(valid2), .result_ready_i(ready2)
  );

  always @(negedge clk) begin
    assert (!(sample && strobe)) else begin
      bad++;
      $error("FAIL overlap dut sample=%0b strobe=%0b expected not both", sample, strobe);
    end
    assert (!(sample2 && strobe2)) else begin
      bad++;
      $error("FAIL overlap dut2 sample=%0b strobe=%0b expected not both", sample2, strobe2);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    trials.delete();
    while (!valid && n < 200) begin
      if (strobe) trials.push_back(data);
      tick();
      n++;
    end
  endtask

  task automatic run_conv(input logic [11:0] v, input int mode, output int n);
    vin       = v;
    comp_mode = mode;
    start_i   = 1'b1;
    tick();
    check("accept_sample", {31'd0, sample}, 32'd1);
    start_i = 1'b0;
    wait_result(n);
    $display("conv vin=%03h mode=%0d result=%03h latency=%0d strobes=%0d",
             v, mode, result, n, trials.size());
  endtask

  task automatic handshake();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("hs_valid_drop", {31'd0, valid}, 32'd0);
    check("hs_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, s, g, cnt;
    logic seen_valid;

    rst = 1'b1; start_i = 1'b0; ready = 1'b0; vin = '0; comp_mode = 0;
    start2 = 1'b0; ready2 = 1'b0; vin2 = '0;
    tick(); tick();
    check("rst_sample", {31'd0, sample}, 32'd0);
    check("rst_strobe", {31'd0, strobe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {20'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_result", {20'd0, result}, 32'd0);
    rst = 1'b0;
    tick();

    // Comparator model, Vin = 0xA5C
    run_conv(12'hA5C, 0, n);
    check("a5c_latency", n, 28);
    check("a5c_result", {20'd0, result}, 32'hA5C);
    check("a5c_valid", {31'd0, valid}, 32'd1);
    check("a5c_done_data", {20'd0, data}, 32'hA5C);

    // Hold result in DONE with start asserted; start must be ignored
    start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", {31'd0, valid}, 32'd1);
      check("hold_result", {20'd0, result}, 32'hA5C);
      check("hold_busy", {31'd0, busy}, 32'd0);
    end
    start_i = 1'b0;
    handshake();
    tick();
    check("idle_after_hs_sample", {31'd0, sample}, 32'd0);
    check("idle_after_hs_busy", {31'd0, busy}, 32'd0);

    // Comparator tied high
    run_conv(12'h000, 1, n);
    check("tie1_latency", n, 28);
    check("tie1_result", {20'd0, result}, 32'hFFF);
    check("tie1_ntrials", trials.size(), 12);
    for (int i = 0; i < trials.size(); i++)
      check("tie1_trial", {20'd0, trials[i]}, {20'd0, ~(12'h7FF >> i)});
    handshake();

    // Comparator tied low
    run_conv(12'hFFF, 2, n);
    check("tie0_latency", n, 28);
    check("tie0_result", {20'd0, result}, 32'h000);
    check("tie0_ntrials", trials.size(), 12);
    for (int i = 0; i < trials.size(); i++)
      check("tie0_trial", {20'd0, trials[i]}, {20'd0, 12'h800 >> i});
    handshake();

    // Back-to-back: ready and start together in DONE
    run_conv(12'h123, 0, n);
    check("b2b_first_result", {20'd0, result}, 32'h123);
    vin     = 12'h9E7;
    ready   = 1'b1;
    start_i = 1'b1;
    tick();
    ready   = 1'b0;
    start_i = 1'b0;
    check("b2b_valid_drop", {31'd0, valid}, 32'd0);
    check("b2b_sample_now", {31'd0, sample}, 32'd1);
    check("b2b_data_zero", {20'd0, data}, 32'd0);
    wait_result(n);
    $display("conv vin=%03h mode=0 result=%03h latency=%0d strobes=%0d (back-to-back)",
             vin, result, n, trials.size());
    check("b2b_latency", n, 28);
    check("b2b_result", {20'd0, result}, 32'h9E7);
    handshake();

    // Reset while bit 6 is being resolved
    vin       = 12'h3C1;
    comp_mode = 0;
    start_i   = 1'b1;
    tick();
    start_i = 1'b0;
    cnt = 0; g = 0;
    while (cnt < 5 && g < 100) begin
      tick();
      g++;
      if (strobe) cnt++;
    end
    tick();
    check("abort_trial_bit6", {20'd0, data}, 32'h3C0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_sample", {31'd0, sample}, 32'd0);
    check("abort_strobe", {31'd0, strobe}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_data", {20'd0, data}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (valid || busy) seen_valid = 1'b1;
    end
    check("abort_stays_idle", {31'd0, seen_valid}, 32'd0);
    $display("conv vin=3c1 aborted by reset at bit 6");
    run_conv(12'h3C1, 0, n);
    check("post_abort_latency", n, 28);
    check("post_abort_result", {20'd0, result}, 32'h3C1);
    handshake();

    // Fast build: one sample cycle, no settle
    vin2   = 12'h5A3;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("fast_accept_sample", {31'd0, sample2}, 32'd1);
    n = 0; s = 0;
    while (!valid2 && n < 100) begin
      if (strobe2) s++;
      tick();
      n++;
    end
    $display("conv fast vin=%03h result=%03h latency=%0d strobes=%0d", vin2, result2, n, s);
    check("fast_latency", n, 13);
    check("fast_strobes", s, 12);
    check("fast_result", {20'd0, result2}, 32'h5A3);
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    check("fast_hs_valid", {31'd0, valid2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
